// File: rtl/simple_memory_arbiter.sv
// Round-robin sequencer sharing one single-port register memory between two requesters.
// Each access takes three cycles: IDLE (arbitrate), ACCESS (memory strobe), DONE (ack).
module simple_memory_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_ptr;
  logic                r_winner;
  logic                r_ack0;
  logic                r_ack1;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                r_mem_we;
  logic                r_mem_re;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_din;
  logic                r_busy;

  logic                w_any_req;
  logic                w_grant;
  logic                w_sel_wr;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;

  // Requester 1 wins when it is alone, or when both ask and the pointer favours it.
  assign w_any_req   = req0 | req1;
  assign w_grant     = req1 & (~req0 | r_ptr);
  assign w_sel_wr    = w_grant ? wr1    : wr0;
  assign w_sel_addr  = w_grant ? addr1  : addr0;
  assign w_sel_wdata = w_grant ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next = ACCESS;
      ACCESS:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= 1'b0;
      r_winner   <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_winner   <= w_grant;
            r_mem_addr <= w_sel_addr;
            r_mem_din  <= w_sel_wdata;
            r_mem_we   <= w_sel_wr;
            r_mem_re   <= ~w_sel_wr;
            r_busy     <= 1'b1;
          end
        end
        ACCESS: begin
          // Writes report zero read data; the loser's outputs are left alone.
          r_mem_we <= 1'b0;
          r_mem_re <= 1'b0;
          if (r_winner) begin
            r_ack1   <= 1'b1;
            r_rdata1 <= r_mem_re ? mem_dout : '0;
          end else begin
            r_ack0   <= 1'b1;
            r_rdata0 <= r_mem_re ? mem_dout : '0;
          end
        end
        DONE: begin
          r_ack0 <= 1'b0;
          r_ack1 <= 1'b0;
          r_busy <= 1'b0;
          r_ptr  <= ~r_winner;
        end
        default: begin
          r_ack0   <= 1'b0;
          r_ack1   <= 1'b0;
          r_mem_we <= 1'b0;
          r_mem_re <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;
  assign mem_we      = r_mem_we;
  assign mem_re      = r_mem_re;
  assign mem_addr    = r_mem_addr;
  assign mem_din     = r_mem_din;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_simple_memory_arbiter.sv
// Directed bench for simple_memory_arbiter with a behavioural 8x8 memory attached
// to the mem_* pins; outputs are sampled 1 time unit after each rising edge.
module tb_simple_memory_arbiter;

  localparam logic [7:0] S_IDLE   = 8'd0;
  localparam logic [7:0] S_ACCESS = 8'd1;
  localparam logic [7:0] S_DONE   = 8'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, wr0, req1, wr1;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       mem_we, mem_re;
  logic [2:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic       busy;
  logic [1:0] dbg_state;

  logic [7:0] mem [8];
  logic [7:0] exp_rd0, exp_rd1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Memory model: synchronous write, combinational read gated by re.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_din;
  assign mem_dout = mem_re ? mem[mem_addr] : 8'h00;

  simple_memory_arbiter #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .o_dbg_state(dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit who, input logic wr, input logic [2:0] a, input logic [7:0] d);
    if (!who) begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = d; end
    else      begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = d; end
  endtask

  // Checks the ack cycle for winner `who`; loser must keep its previous rdata.
  task automatic chk_ack(input string tag, input bit who, input logic wr, input logic [7:0] exp_rd);
    if (!who) exp_rd0 = wr ? 8'h00 : exp_rd;
    else      exp_rd1 = wr ? 8'h00 : exp_rd;
    chk({tag, "_ack0"},   8'(ack0), 8'(!who));
    chk({tag, "_ack1"},   8'(ack1), 8'(who));
    chk({tag, "_rdata0"}, rdata0, exp_rd0);
    chk({tag, "_rdata1"}, rdata1, exp_rd1);
    chk({tag, "_state"},  8'(dbg_state), S_DONE);
    chk({tag, "_we_off"}, 8'({mem_we, mem_re}), 8'd0);
  endtask

  // One complete access by a lone requester, dropped in its ack cycle.
  task automatic do_access(input string tag, input bit who, input logic wr,
                           input logic [2:0] a, input logic [7:0] d, input logic [7:0] exp_rd);
    drive(who, wr, a, d);
    step();
    chk({tag, "_acc_state"}, 8'(dbg_state), S_ACCESS);
    chk({tag, "_acc_we"},    8'(mem_we), 8'(wr));
    chk({tag, "_acc_re"},    8'(mem_re), 8'(!wr));
    chk({tag, "_acc_addr"},  8'(mem_addr), 8'(a));
    chk({tag, "_acc_busy"},  8'(busy), 8'd1);
    step();
    chk_ack(tag, who, wr, exp_rd);
    if (!who) req0 = 1'b0; else req1 = 1'b0;
    step();
    chk({tag, "_idle_state"}, 8'(dbg_state), S_IDLE);
    chk({tag, "_idle_acks"},  8'({ack0, ack1, busy}), 8'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
    exp_rd0 = 8'h00; exp_rd1 = 8'h00;

    // 1: reset for two cycles, then idle
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_state",  8'(dbg_state), S_IDLE);
    chk("rst_ctrl",   8'({ack0, ack1, mem_we, mem_re, busy}), 8'd0);
    chk("rst_addr",   8'(mem_addr), 8'd0);
    chk("rst_din",    mem_din, 8'd0);
    chk("rst_rdata0", rdata0, 8'd0);
    chk("rst_rdata1", rdata1, 8'd0);

    // 2: write then read back through requester 0
    do_access("t2_wr", 1'b0, 1'b1, 3'd5, 8'hA5, 8'h00);
    chk("t2_we_pulse", 8'(mem_we), 8'd0);
    do_access("t2_rd", 1'b0, 1'b0, 3'd5, 8'h00, 8'hA5);

    // Preload addresses 1 and 2 through requester 1 (pointer ends at 0)
    do_access("pre1", 1'b1, 1'b1, 3'd1, 8'h11, 8'h00);
    do_access("pre2", 1'b1, 1'b1, 3'd2, 8'h22, 8'h00);

    // 3: both reading continuously -> strict alternation 0,1,0,1
    drive(1'b0, 1'b0, 3'd1, 8'h00);
    drive(1'b1, 1'b0, 3'd2, 8'h00);
    for (int i = 0; i < 4; i++) begin
      bit win;
      win = (i % 2) == 1;
      step();
      chk("t3_acc_state", 8'(dbg_state), S_ACCESS);
      chk("t3_acc_addr",  8'(mem_addr), win ? 8'd2 : 8'd1);
      step();
      chk_ack("t3", win, 1'b0, win ? 8'h22 : 8'h11);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      step();
      chk("t3_idle_state", 8'(dbg_state), S_IDLE);
    end

    // 4: only requester 1, pointer favouring 0 -> served every 3 cycles
    drive(1'b1, 1'b0, 3'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_acc_state", 8'(dbg_state), S_ACCESS);
      step();
      chk_ack("t4", 1'b1, 1'b0, 8'h22);
      if (i == 2) req1 = 1'b0;
      step();
      chk("t4_idle_state", 8'(dbg_state), S_IDLE);
    end
    chk("t4_rdata0_kept", rdata0, 8'h11);

    // 5: reset during ACCESS of a write; write still lands, no ack
    drive(1'b1, 1'b1, 3'd7, 8'h3C);
    step();
    chk("t5_acc_we", 8'(mem_we), 8'd1);
    rst = 1'b1;
    req1 = 1'b0;
    step();
    chk("t5_no_ack",   8'({ack0, ack1}), 8'd0);
    chk("t5_state",    8'(dbg_state), S_IDLE);
    chk("t5_ctrl",     8'({mem_we, mem_re, busy}), 8'd0);
    chk("t5_addr",     8'(mem_addr), 8'd0);
    chk("t5_din",      mem_din, 8'd0);
    chk("t5_rdata0",   rdata0, 8'd0);
    chk("t5_rdata1",   rdata1, 8'd0);
    exp_rd0 = 8'h00; exp_rd1 = 8'h00;
    rst = 1'b0;
    step();
    chk("t5_post_idle", 8'(dbg_state), S_IDLE);
    do_access("t5_rd", 1'b1, 1'b0, 3'd7, 8'h00, 8'h3C);

    // 6: write from 0 and read from 1 to the same address, pointer at 0
    drive(1'b0, 1'b1, 3'd3, 8'h5A);
    drive(1'b1, 1'b0, 3'd3, 8'hEE);
    step();
    chk("t6_acc_we",   8'(mem_we), 8'd1);
    chk("t6_acc_addr", 8'(mem_addr), 8'd3);
    chk("t6_acc_din",  mem_din, 8'h5A);
    step();
    chk_ack("t6_wr", 1'b0, 1'b1, 8'h00);
    req0 = 1'b0;
    step();
    chk("t6_idle", 8'(dbg_state), S_IDLE);
    step();
    chk("t6_rd_re", 8'(mem_re), 8'd1);
    step();
    chk_ack("t6_rd", 1'b1, 1'b0, 8'h5A);
    req1 = 1'b0;
    step();
    chk("t6_end_state", 8'(dbg_state), S_IDLE);
    chk("t6_addr_hold", 8'(mem_addr), 8'd3);
    chk("t6_din_hold",  mem_din, 8'hEE);
    chk("t6_strobes",   8'({mem_we, mem_re, busy}), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
